// File: rtl/sm_result_buffer.sv
// -----------------------------------------------------------------------------
// sm_result_buffer
//
// Two-entry output buffer that sits directly after the sign-magnitude
// add/subtract unit. Each accepted result is normalised as it is captured:
// negative zero becomes positive zero, and a two's-complement copy is stored
// next to it. The buffer also keeps a saturating count of accepted results
// that carried out of the magnitude, so the datapath can be stalled without
// losing results or overflow events.
//
// Ports
//   clk        rising-edge clock
//   rst        asynchronous active-high reset
//   in_valid   upstream result valid
//   in_data    upstream sign-magnitude result (MSB = sign)
//   in_carry   upstream magnitude carry/borrow for this result
//   o_ready    buffer can accept a result this cycle (state only)
//   in_ready   downstream accepts the head entry
//   o_valid    head entry valid
//   o_data     head entry, sign-magnitude, negative zero removed
//   o_data_tc  head entry in two's complement
//   o_ovf      head entry was produced with carry set
//   in_clr     synchronous clear of the overflow counter
//   o_ovf_cnt  saturating count of accepted results with carry set
//
// States
//   state | meaning
//   EMPTY | no entry held, o_valid low
//   ONE   | head entry valid, tail slot free
//   FULL  | head and tail valid, o_ready low
// -----------------------------------------------------------------------------
module sm_result_buffer #(
    parameter int N     = 8,
    parameter int CNT_W = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    input  logic [N-1:0]     in_data,
    input  logic             in_carry,
    output logic             o_ready,
    input  logic             in_ready,
    output logic             o_valid,
    output logic [N-1:0]     o_data,
    output logic [N-1:0]     o_data_tc,
    output logic             o_ovf,
    input  logic             in_clr,
    output logic [CNT_W-1:0] o_ovf_cnt
);

    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        ONE   = 2'd1,
        FULL  = 2'd2
    } state_t;

    localparam logic [N-1:0]     ONE_N   = {{(N-1){1'b0}}, 1'b1};
    localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};
    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    state_t           state_q, state_d;

    logic [N-1:0]     head_data_q, head_data_d;
    logic [N-1:0]     head_tc_q,   head_tc_d;
    logic             head_ovf_q,  head_ovf_d;
    logic [N-1:0]     tail_data_q, tail_data_d;
    logic [N-1:0]     tail_tc_q,   tail_tc_d;
    logic             tail_ovf_q,  tail_ovf_d;

    logic [CNT_W-1:0] cnt_q, cnt_d;

    logic             push;
    logic             pop;
    logic             ovf_push;

    logic [N-2:0]     new_mag;
    logic             new_sgn;
    logic [N-1:0]     new_data;
    logic [N-1:0]     new_tc;

    // Handshake. o_ready is a function of state (and reset) only, so the
    // upstream never sees a combinational path from in_ready.
    assign o_ready  = !rst && (state_q != FULL);
    assign o_valid  = (state_q != EMPTY);
    assign push     = in_valid && o_ready;
    assign pop      = o_valid && in_ready;
    assign ovf_push = push && in_carry;

    // Normalise the incoming word once, at capture time. A zero magnitude
    // always gets a positive sign; the magnitude is at most 2^(N-1)-1, so the
    // negated value always fits in N bits.
    assign new_mag  = in_data[N-2:0];
    assign new_sgn  = in_data[N-1] && (new_mag != '0);
    assign new_data = {new_sgn, new_mag};
    assign new_tc   = new_sgn ? (~{1'b0, new_mag} + ONE_N) : {1'b0, new_mag};

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= EMPTY;
            head_data_q <= '0;
            head_tc_q   <= '0;
            head_ovf_q  <= 1'b0;
            tail_data_q <= '0;
            tail_tc_q   <= '0;
            tail_ovf_q  <= 1'b0;
        end else begin
            state_q     <= state_d;
            head_data_q <= head_data_d;
            head_tc_q   <= head_tc_d;
            head_ovf_q  <= head_ovf_d;
            tail_data_q <= tail_data_d;
            tail_tc_q   <= tail_tc_d;
            tail_ovf_q  <= tail_ovf_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        head_data_d = head_data_q;
        head_tc_d   = head_tc_q;
        head_ovf_d  = head_ovf_q;
        tail_data_d = tail_data_q;
        tail_tc_d   = tail_tc_q;
        tail_ovf_d  = tail_ovf_q;

        case (state_q)
            EMPTY: begin
                if (push) begin
                    state_d     = ONE;
                    head_data_d = new_data;
                    head_tc_d   = new_tc;
                    head_ovf_d  = in_carry;
                end
            end
            ONE: begin
                if (push && pop) begin
                    // Head leaves this cycle; the new word takes its place.
                    head_data_d = new_data;
                    head_tc_d   = new_tc;
                    head_ovf_d  = in_carry;
                end else if (push) begin
                    state_d     = FULL;
                    tail_data_d = new_data;
                    tail_tc_d   = new_tc;
                    tail_ovf_d  = in_carry;
                end else if (pop) begin
                    state_d     = EMPTY;
                end
            end
            FULL: begin
                if (pop) begin
                    state_d     = ONE;
                    head_data_d = tail_data_q;
                    head_tc_d   = tail_tc_q;
                    head_ovf_d  = tail_ovf_q;
                end
            end
            default: begin
                state_d = EMPTY;
            end
        endcase
    end

    assign o_data    = head_data_q;
    assign o_data_tc = head_tc_q;
    assign o_ovf     = head_ovf_q;

    // Overflow-event counter. A clear coinciding with an overflow push still
    // records that event, so the result is 1 rather than 0.
    always_comb begin
        cnt_d = cnt_q;
        if (in_clr) begin
            cnt_d = ovf_push ? CNT_ONE : '0;
        end else if (ovf_push && (cnt_q != CNT_MAX)) begin
            cnt_d = cnt_q + CNT_ONE;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign o_ovf_cnt = cnt_q;

endmodule

// File: tb/tb_sm_result_buffer.sv
module tb_sm_result_buffer;

    localparam int N     = 8;
    localparam int CNT_W = 4;

    logic             clk = 1'b0;
    logic             rst;
    logic             in_valid;
    logic [N-1:0]     in_data;
    logic             in_carry;
    logic             o_ready;
    logic             in_ready;
    logic             o_valid;
    logic [N-1:0]     o_data;
    logic [N-1:0]     o_data_tc;
    logic             o_ovf;
    logic             in_clr;
    logic [CNT_W-1:0] o_ovf_cnt;

    int nvec = 0;
    int nerr = 0;

    always #5 clk = ~clk;

    sm_result_buffer #(.N(N), .CNT_W(CNT_W)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_data   (in_data),
        .in_carry  (in_carry),
        .o_ready   (o_ready),
        .in_ready  (in_ready),
        .o_valid   (o_valid),
        .o_data    (o_data),
        .o_data_tc (o_data_tc),
        .o_ovf     (o_ovf),
        .in_clr    (in_clr),
        .o_ovf_cnt (o_ovf_cnt)
    );

    // Advance one clock; inputs are driven and outputs sampled 1 ns after the edge.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst      = 1'b1;
        in_valid = 1'b0;
        in_data  = '0;
        in_carry = 1'b0;
        in_ready = 1'b0;
        in_clr   = 1'b0;
        step();
        step();
        nvec++; if (o_valid !== 1'b0) begin nerr++; $display("FAIL reset_valid got %b exp 0", o_valid); end
        nvec++; if (o_ready !== 1'b0) begin nerr++; $display("FAIL reset_ready got %b exp 0", o_ready); end
        nvec++; if (o_data !== 8'h00) begin nerr++; $display("FAIL reset_data got %h exp 00", o_data); end
        nvec++; if (o_data_tc !== 8'h00) begin nerr++; $display("FAIL reset_tc got %h exp 00", o_data_tc); end
        nvec++; if (o_ovf !== 1'b0) begin nerr++; $display("FAIL reset_ovf got %b exp 0", o_ovf); end
        nvec++; if (o_ovf_cnt !== 4'd0) begin nerr++; $display("FAIL reset_cnt got %0d exp 0", o_ovf_cnt); end
        rst = 1'b0;
        #1;
        nvec++; if (o_ready !== 1'b1) begin nerr++; $display("FAIL release_ready got %b exp 1", o_ready); end
    endtask

    task automatic test_single();
        in_ready = 1'b1;
        in_valid = 1'b1;
        in_data  = 8'h85;
        in_carry = 1'b0;
        step();
        in_valid = 1'b0;
        nvec++; if (o_valid !== 1'b1) begin nerr++; $display("FAIL single_valid got %b exp 1", o_valid); end
        nvec++; if (o_data !== 8'h85) begin nerr++; $display("FAIL single_data got %h exp 85", o_data); end
        nvec++; if (o_data_tc !== 8'hFB) begin nerr++; $display("FAIL single_tc got %h exp FB", o_data_tc); end
        nvec++; if (o_ovf !== 1'b0) begin nerr++; $display("FAIL single_ovf got %b exp 0", o_ovf); end
        step();
        nvec++; if (o_valid !== 1'b0) begin nerr++; $display("FAIL single_drain got %b exp 0", o_valid); end
    endtask

    task automatic test_zero_and_max();
        in_ready = 1'b1;
        in_valid = 1'b1;
        in_data  = 8'h80;
        in_carry = 1'b0;
        step();
        nvec++; if (o_data !== 8'h00) begin nerr++; $display("FAIL negzero_data got %h exp 00", o_data); end
        nvec++; if (o_data_tc !== 8'h00) begin nerr++; $display("FAIL negzero_tc got %h exp 00", o_data_tc); end
        in_data = 8'h7F;
        step();
        nvec++; if (o_data !== 8'h7F) begin nerr++; $display("FAIL max_data got %h exp 7F", o_data); end
        nvec++; if (o_data_tc !== 8'h7F) begin nerr++; $display("FAIL max_tc got %h exp 7F", o_data_tc); end
        in_data = 8'hFF;
        step();
        nvec++; if (o_data !== 8'hFF) begin nerr++; $display("FAIL negmax_data got %h exp FF", o_data); end
        nvec++; if (o_data_tc !== 8'h81) begin nerr++; $display("FAIL negmax_tc got %h exp 81", o_data_tc); end
        in_valid = 1'b0;
        step();
        nvec++; if (o_valid !== 1'b0) begin nerr++; $display("FAIL zm_drain got %b exp 0", o_valid); end
    endtask

    task automatic test_backpressure();
        in_ready = 1'b0;
        in_valid = 1'b1;
        in_carry = 1'b0;
        in_data  = 8'h01;
        step();
        nvec++; if (o_ready !== 1'b1) begin nerr++; $display("FAIL bp_ready1 got %b exp 1", o_ready); end
        nvec++; if (o_data !== 8'h01) begin nerr++; $display("FAIL bp_head1 got %h exp 01", o_data); end
        in_data = 8'h02;
        step();
        nvec++; if (o_ready !== 1'b0) begin nerr++; $display("FAIL bp_full_ready got %b exp 0", o_ready); end
        nvec++; if (o_data !== 8'h01) begin nerr++; $display("FAIL bp_head_stable got %h exp 01", o_data); end
        in_data = 8'h03;
        step();
        nvec++; if (o_ready !== 1'b0) begin nerr++; $display("FAIL bp_hold_ready got %b exp 0", o_ready); end
        nvec++; if (o_data !== 8'h01) begin nerr++; $display("FAIL bp_hold_head got %h exp 01", o_data); end
        in_ready = 1'b1;
        step();
        nvec++; if (o_data !== 8'h02) begin nerr++; $display("FAIL bp_out2 got %h exp 02", o_data); end
        nvec++; if (o_ready !== 1'b1) begin nerr++; $display("FAIL bp_ready_after_pop got %b exp 1", o_ready); end
        step();
        in_valid = 1'b0;
        nvec++; if (o_data !== 8'h03) begin nerr++; $display("FAIL bp_out3 got %h exp 03", o_data); end
        nvec++; if (o_valid !== 1'b1) begin nerr++; $display("FAIL bp_valid3 got %b exp 1", o_valid); end
        step();
        nvec++; if (o_valid !== 1'b0) begin nerr++; $display("FAIL bp_drain got %b exp 0", o_valid); end
    endtask

    task automatic test_back_to_back();
        in_ready = 1'b1;
        in_valid = 1'b1;
        in_carry = 1'b0;
        for (int v = 1; v <= 10; v++) begin
            in_data = 8'(v);
            step();
            nvec++; if (o_data !== 8'(v)) begin nerr++; $display("FAIL b2b_data[%0d] got %h exp %h", v, o_data, 8'(v)); end
            nvec++; if (o_ready !== 1'b1) begin nerr++; $display("FAIL b2b_ready[%0d] got %b exp 1", v, o_ready); end
        end
        in_valid = 1'b0;
        step();
        nvec++; if (o_valid !== 1'b0) begin nerr++; $display("FAIL b2b_drain got %b exp 0", o_valid); end
    endtask

    task automatic test_ovf_counter();
        int exp_cnt;
        in_ready = 1'b1;
        in_valid = 1'b1;
        in_carry = 1'b1;
        for (int i = 1; i <= 20; i++) begin
            in_data = 8'(i);
            step();
            exp_cnt = (i > 15) ? 15 : i;
            nvec++; if (o_ovf !== 1'b1) begin nerr++; $display("FAIL ovf_flag[%0d] got %b exp 1", i, o_ovf); end
            nvec++; if (o_ovf_cnt !== 4'(exp_cnt)) begin nerr++; $display("FAIL ovf_cnt[%0d] got %0d exp %0d", i, o_ovf_cnt, exp_cnt); end
        end
        in_clr  = 1'b1;
        in_data = 8'h33;
        step();
        in_clr   = 1'b0;
        in_valid = 1'b0;
        in_carry = 1'b0;
        nvec++; if (o_ovf_cnt !== 4'd1) begin nerr++; $display("FAIL clr_with_ovf got %0d exp 1", o_ovf_cnt); end
        step();
        nvec++; if (o_valid !== 1'b0) begin nerr++; $display("FAIL ovf_drain got %b exp 0", o_valid); end
        nvec++; if (o_ovf_cnt !== 4'd1) begin nerr++; $display("FAIL cnt_hold got %0d exp 1", o_ovf_cnt); end
    endtask

    task automatic test_reset_midop();
        in_ready = 1'b0;
        in_valid = 1'b1;
        in_carry = 1'b1;
        in_data  = 8'h11;
        step();
        in_data = 8'h22;
        step();
        in_valid = 1'b0;
        in_carry = 1'b0;
        nvec++; if (o_ovf_cnt !== 4'd3) begin nerr++; $display("FAIL pre_rst_cnt got %0d exp 3", o_ovf_cnt); end
        nvec++; if (o_ready !== 1'b0) begin nerr++; $display("FAIL pre_rst_full got %b exp 0", o_ready); end
        #2;
        rst = 1'b1;
        #1;
        nvec++; if (o_valid !== 1'b0) begin nerr++; $display("FAIL rst_mid_valid got %b exp 0", o_valid); end
        nvec++; if (o_ready !== 1'b0) begin nerr++; $display("FAIL rst_mid_ready got %b exp 0", o_ready); end
        nvec++; if (o_ovf_cnt !== 4'd0) begin nerr++; $display("FAIL rst_mid_cnt got %0d exp 0", o_ovf_cnt); end
        step();
        rst      = 1'b0;
        in_ready = 1'b1;
        #1;
        nvec++; if (o_ready !== 1'b1) begin nerr++; $display("FAIL post_rst_ready got %b exp 1", o_ready); end
        step();
        step();
        nvec++; if (o_valid !== 1'b0) begin nerr++; $display("FAIL no_replay got %b exp 0", o_valid); end
        in_valid = 1'b1;
        in_data  = 8'h55;
        step();
        in_valid = 1'b0;
        nvec++; if (o_data !== 8'h55) begin nerr++; $display("FAIL post_rst_data got %h exp 55", o_data); end
        step();
        nvec++; if (o_valid !== 1'b0) begin nerr++; $display("FAIL post_rst_drain got %b exp 0", o_valid); end
    endtask

    initial begin
        test_reset();
        test_single();
        test_zero_and_max();
        test_backpressure();
        test_back_to_back();
        test_ovf_counter();
        test_reset_midop();
        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end

endmodule
